// File: rtl/cpu_ctrl_if.sv
// Instruction/data memory handshake bundle for the multicycle controller.
// master = controller side, slave = memory side.
interface cpu_ctrl_if;
    logic [15:0] ins_in;
    logic        imem_ready_in;
    logic        imem_req_out;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic        dmem_ready_in;

    modport master (
        input  ins_in,
        input  imem_ready_in,
        input  dmem_ready_in,
        output imem_req_out,
        output dmem_req_out,
        output dmem_we_out
    );

    modport slave (
        output ins_in,
        output imem_ready_in,
        output dmem_ready_in,
        input  imem_req_out,
        input  dmem_req_out,
        input  dmem_we_out
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Multicycle control unit for the 16-bit core: fetch, decode, exec, mem.
// Optional macro CPU_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT.
module cpu_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_ctrl_if.master       bus,
    output logic             ir_load_out,
    output logic [15:0]      ir_out,
    input  logic             z_in,
    input  logic             n_in,
    output logic [2:0]       alu_op_out,
    output logic             rf_we_out,
    output logic [1:0]       ps_out,
    output logic             halted_out,
    output logic             bus_err_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] instret_out
);

    localparam logic [2:0] BOOT   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_REG  = 2'b11;

    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (WAIT_MAX == 0) ? '0 : WAIT_W'(WAIT_MAX - 1);

    logic [2:0]        state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              bus_err_q, bus_err_d;
    logic              ill_pulse;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic              illegal_q, illegal_d;
`endif

    logic [3:0] opc;
    logic [2:0] cond;
    logic       op_nop, op_alu, op_ld, op_st;
    logic       op_br, op_jr, op_hlt;
    logic       br_take;
    logic       timeout;

    assign opc    = ir_q[15:12];
    assign cond   = ir_q[11:9];
    assign op_nop = (opc == 4'h0);
    assign op_alu = (opc == 4'h1);
    assign op_ld  = (opc == 4'h2);
    assign op_st  = (opc == 4'h3);
    assign op_br  = (opc == 4'h4);
    assign op_jr  = (opc == 4'h5);
    assign op_hlt = (opc == 4'hF);

    // Ready low in the WAIT_MAX-th cycle of a wait is a bus error.
    assign timeout = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        br_take = 1'b0;
        case (cond)
            3'b000:  br_take = 1'b1;
            3'b001:  br_take = z_in;
            3'b010:  br_take = !z_in;
            3'b011:  br_take = n_in;
            3'b100:  br_take = !n_in;
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        wait_d           = '0;
        bus_err_d        = bus_err_q;
        ill_pulse        = 1'b0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        illegal_d        = illegal_q;
`endif
        bus.imem_req_out = 1'b0;
        bus.dmem_req_out = 1'b0;
        bus.dmem_we_out  = 1'b0;
        ir_load_out      = 1'b0;
        alu_op_out       = 3'b000;
        rf_we_out        = 1'b0;
        ps_out           = PS_HOLD;

        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                bus.imem_req_out = 1'b1;
                if (bus.imem_ready_in) begin
                    ir_load_out = 1'b1;
                    ir_d        = bus.ins_in;
                    state_d     = DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                unique case (1'b1)
                    op_nop: ps_out = PS_INC;
                    op_alu: begin
                        alu_op_out = ir_q[11:9];
                        rf_we_out  = 1'b1;
                        ps_out     = PS_INC;
                    end
                    op_ld, op_st: state_d = MEM;
                    op_br: ps_out = br_take ? PS_BR : PS_INC;
                    op_jr: ps_out = PS_REG;
                    op_hlt: state_d = HALT;
                    default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = HALT;
`else
                        ill_pulse = 1'b1;
                        ps_out    = PS_INC;
`endif
                    end
                endcase
            end
            MEM: begin
                bus.dmem_req_out = 1'b1;
                bus.dmem_we_out  = op_st;
                if (bus.dmem_ready_in) begin
                    rf_we_out = op_ld;
                    ps_out    = PS_INC;
                    state_d   = FETCH;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
        endcase

        instret_d = instret_q;
        if (ps_out != PS_HOLD)
            instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            ir_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else
            illegal_q <= illegal_d;
    end

    assign illegal_out = illegal_q | ill_pulse;
`else
    assign illegal_out = ill_pulse;
`endif

    assign ir_out      = ir_q;
    assign halted_out  = (state_q == HALT);
    assign bus_err_out = bus_err_q;
    assign instret_out = instret_q;

endmodule
